// File: rtl/alu_seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per cycle from a trial
// subtraction, with valid/ready handshakes on operand and result sides.
module alu_seq_divider #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dbz_q, dbz_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH:0]   trial_s;
    logic [WIDTH:0]   diff_s;

    // Shifted partial remainder minus divisor; bit WIDTH of the result is the borrow.
    function automatic logic [WIDTH:0] trial_sub(input logic [WIDTH:0]   t,
                                                 input logic [WIDTH-1:0] dvs);
        trial_sub = t - {1'b0, dvs};
    endfunction

    // State register, datapath registers and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            dbz_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            dbz_q       <= dbz_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state and datapath update for the IDLE/BUSY/DONE sequencer.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
        trial_s = {rem_q, quo_q[WIDTH-1]};
        diff_s  = trial_sub(trial_s, dvs_q);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dvs_d = divisor;
                    if (divisor != '0) begin
                        rem_d   = '0;
                        quo_d   = dividend;
                        cnt_d   = CW'(WIDTH - 1);
                        dbz_d   = 1'b0;
                        state_d = BUSY;
                    end else begin
                        rem_d   = dividend;
                        quo_d   = {WIDTH{1'b1}};
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (!diff_s[WIDTH]) begin
                    rem_d = diff_s[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = trial_s[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_seq_divider.sv
// Directed-table and exhaustive-sweep bench for alu_seq_divider (WIDTH=6),
// covering latency, backpressure, divide-by-zero and mid-operation reset.
module tb_alu_seq_divider;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int total = 0;
    int bad = 0;

    alu_seq_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        int dbz;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One complete operation: accept, latency count (accept edge = edge 1), hold, handshake.
    task automatic run_op(input int a, input int b, input int eq, input int er,
                          input int edbz, input int stall, input string tag);
        int n;
        bit seen;
        @(negedge clk);
        dividend  = W'(a);
        divisor   = W'(b);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_ready_after_accept"}, int'(in_ready), 0);
        n    = 1;
        seen = out_valid;
        @(negedge clk);
        in_valid = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        while (!seen && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            seen = out_valid;
        end
        chk({tag, "_latency"}, n, (edbz != 0) ? 1 : W + 1);
        chk({tag, "_quotient"}, int'(quotient), eq);
        chk({tag, "_remainder"}, int'(remainder), er);
        chk({tag, "_dbz"}, int'(div_by_zero), edbz);
        if (edbz == 0) begin
            chk({tag, "_invariant"},
                int'((int'(quotient) * b + int'(remainder) == a) && (int'(remainder) < b)), 1);
        end
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            #1;
            chk({tag, "_hold"}, {out_valid, in_ready, div_by_zero, quotient, remainder},
                {1'b1, 1'b0, edbz[0], 6'(eq), 6'(er)});
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, "_release"}, {out_valid, in_ready}, {1'b0, 1'b1});
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{30, 3, 10, 0, 0};
        vecs[1]  = '{63, 1, 63, 0, 0};
        vecs[2]  = '{5, 7, 0, 5, 0};
        vecs[3]  = '{13, 0, 63, 13, 1};
        vecs[4]  = '{36, 5, 7, 1, 0};
        vecs[5]  = '{0, 5, 0, 0, 0};
        vecs[6]  = '{63, 63, 1, 0, 0};
        vecs[7]  = '{62, 63, 0, 62, 0};
        vecs[8]  = '{1, 0, 63, 1, 1};
        vecs[9]  = '{0, 0, 63, 0, 1};
        vecs[10] = '{45, 6, 7, 3, 0};
        vecs[11] = '{50, 7, 7, 1, 0};
        vecs[12] = '{32, 2, 16, 0, 0};
        vecs[13] = '{17, 4, 4, 1, 0};

        // reset state
        #12;
        chk("reset_state", {in_ready, out_valid, div_by_zero, quotient, remainder},
            {1'b1, 1'b0, 1'b0, 6'd0, 6'd0});
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz, i % 3,
                   $sformatf("vec%0d", i));
        end

        // backpressure on 45/6 with ignored in_valid pulses while DONE
        begin
            int n;
            @(negedge clk);
            dividend = 6'd45; divisor = 6'd6; in_valid = 1'b1; out_ready = 1'b0;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            n = 0;
            while (!out_valid && n < 40) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("bp_reached_done", int'(out_valid), 1);
            for (int s = 0; s < 4; s++) begin
                @(negedge clk);
                in_valid = s[0] ? 1'b0 : 1'b1;
                dividend = 6'd1; divisor = 6'd1;
                @(posedge clk);
                #1;
                chk("bp_hold", {out_valid, in_ready, div_by_zero, quotient, remainder},
                    {1'b1, 1'b0, 1'b0, 6'd7, 6'd3});
            end
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = 1'b1;
            @(posedge clk);
            #1;
            chk("bp_to_idle", {out_valid, in_ready}, {1'b0, 1'b1});
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b0;
            @(posedge clk);
            #1;
            chk("bp_done_edge_valid_ignored", {out_valid, in_ready}, {1'b0, 1'b1});
        end

        // reset asserted on the third BUSY cycle of 50/7
        @(negedge clk);
        dividend = 6'd50; divisor = 6'd7; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_reset_outputs", {in_ready, out_valid, div_by_zero, quotient, remainder},
            {1'b1, 1'b0, 1'b0, 6'd0, 6'd0});
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_reset_no_result", {in_ready, out_valid}, {1'b1, 1'b0});
        run_op(50, 7, 7, 1, 0, 1, "after_reset");

        // exhaustive sweep with random result stalls
        for (int a = 0; a < 64; a++) begin
            for (int b = 0; b < 64; b++) begin
                run_op(a, b, (b == 0) ? 63 : a / b, (b == 0) ? a : a % b,
                       (b == 0) ? 1 : 0, int'($urandom_range(0, 2)),
                       $sformatf("sweep_%0d_%0d", a, b));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
